// File: rtl/sobel_window_gen.sv
// 3x3 window generator: two line buffers plus a 3-column shift register.
// Define SOBEL_WIN_ZERO_BORDER_EN to force out-of-frame taps to zero.
module sobel_window_gen #(
   parameter int DATA_W = 10,
   parameter int LINE_W = 640,
   parameter int ADDR_W = 10,
   parameter int ROW_W  = 10
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iSOF,
   input  logic [DATA_W-1:0]     iDATA,
   input  logic                  iDVAL,
   output logic [9*DATA_W-1:0]   oWIN,
   output logic                  oDVAL,
   output logic                  oBORDER,
   output logic [ADDR_W-1:0]     oX,
   output logic [ROW_W-1:0]      oY
);

   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);
   localparam logic [ROW_W-1:0]  MAX_ROW  = '1;

   logic [DATA_W-1:0] r_lb1 [2**ADDR_W];
   logic [DATA_W-1:0] r_lb2 [2**ADDR_W];
   logic [DATA_W-1:0] r_sh  [9];

   logic [ADDR_W-1:0] r_col;
   logic [ROW_W-1:0]  r_row;
   logic [ADDR_W-1:0] w_col;
   logic [ROW_W-1:0]  w_row;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   // SOF wins over the running position for the pixel in the same cycle
   assign w_col = iSOF ? '0 : r_col;
   assign w_row = iSOF ? '0 : r_row;
   assign w_rd1 = r_lb1[w_col];
   assign w_rd2 = r_lb2[w_col];

   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         r_lb1[w_col] <= iDATA;
         r_lb2[w_col] <= w_rd1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int k = 0; k < 9; k++) r_sh[k] <= '0;
      end else if (iDVAL) begin
         r_sh[0] <= r_sh[1];
         r_sh[1] <= r_sh[2];
         r_sh[2] <= w_rd2;
         r_sh[3] <= r_sh[4];
         r_sh[4] <= r_sh[5];
         r_sh[5] <= w_rd1;
         r_sh[6] <= r_sh[7];
         r_sh[7] <= r_sh[8];
         r_sh[8] <= iDATA;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_col   <= '0;
         r_row   <= '0;
         oDVAL   <= 1'b0;
         oBORDER <= 1'b1;
         oX      <= '0;
         oY      <= '0;
      end else begin
         oDVAL <= iDVAL;
         if (iDVAL) begin
            oX      <= w_col;
            oY      <= w_row;
            oBORDER <= (w_row < ROW_W'(2)) || (w_col < ADDR_W'(2));
            if (w_col == LAST_COL) begin
               r_col <= '0;
               r_row <= (w_row == MAX_ROW) ? w_row : w_row + 1'b1;
            end else begin
               r_col <= w_col + 1'b1;
               r_row <= w_row;
            end
         end else if (iSOF) begin
            r_col <= '0;
            r_row <= '0;
         end
      end
   end

   for (genvar k = 0; k < 9; k++) begin : g_tap
`ifdef SOBEL_WIN_ZERO_BORDER_EN
      localparam int TR = k / 3;
      localparam int TC = k % 3;
      logic w_zero;
      assign w_zero = (TR == 0 && oY < ROW_W'(2))  ||
                      (TR == 1 && oY == '0)        ||
                      (TC == 0 && oX < ADDR_W'(2)) ||
                      (TC == 1 && oX == '0);
      assign oWIN[(8-k)*DATA_W +: DATA_W] = w_zero ? '0 : r_sh[k];
`else
      assign oWIN[(8-k)*DATA_W +: DATA_W] = r_sh[k];
`endif
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen with an 8-pixel line.
module tb_sobel_window_gen;

   localparam int DW = 10;
   localparam int LW = 8;
   localparam int AW = 10;
   localparam int RW = 10;
   localparam int WW = 9 * DW;

   logic          iCLK = 1'b0;
   logic          iRST, iSOF, iDVAL;
   logic [DW-1:0] iDATA;
   logic [WW-1:0] oWIN;
   logic          oDVAL, oBORDER;
   logic [AW-1:0] oX;
   logic [RW-1:0] oY;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [AW-1:0] x;
      logic [RW-1:0] y;
      logic          border;
      logic [WW-1:0] win;
      logic [WW-1:0] care;
   } vec_t;

   vec_t tbl [24];

   sobel_window_gen #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW), .ROW_W(RW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDATA(iDATA), .iDVAL(iDVAL),
      .oWIN(oWIN), .oDVAL(oDVAL), .oBORDER(oBORDER), .oX(oX), .oY(oY)
   );

   always #5 iCLK = ~iCLK;

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [WW-1:0] act,
                      input logic [WW-1:0] exp, input logic [WW-1:0] care);
      checks++;
      if (((act ^ exp) & care) != '0) begin
         errors++;
         $display("FAIL %s: got %h want %h (care %h)", nm, act & care, exp & care, care);
      end
   endtask

   task automatic chk_vec(input string nm, input int n, input logic dv);
      chk($sformatf("%s dval n=%0d", nm, n), WW'(oDVAL), WW'(dv), '1);
      chk($sformatf("%s x n=%0d", nm, n), WW'(oX), WW'(tbl[n].x), '1);
      chk($sformatf("%s y n=%0d", nm, n), WW'(oY), WW'(tbl[n].y), '1);
      chk($sformatf("%s border n=%0d", nm, n), WW'(oBORDER), WW'(tbl[n].border), '1);
      chk($sformatf("%s win n=%0d", nm, n), oWIN, tbl[n].win, tbl[n].care);
   endtask

   task automatic pix(input logic sof, input logic [DW-1:0] d);
      iSOF = sof; iDVAL = 1'b1; iDATA = d;
      step();
      iSOF = 1'b0; iDVAL = 1'b0;
   endtask

   initial begin
      bit zero_en;
`ifdef SOBEL_WIN_ZERO_BORDER_EN
      zero_en = 1'b1;
`else
      zero_en = 1'b0;
`endif
      // ramp stream: value n = row*8+col; tap (i,j) came from pixel n-(2-j), row offset 2-i
      for (int n = 0; n < 24; n++) begin
         int c, r;
         c = n % LW;
         r = n / LW;
         tbl[n].x = AW'(c);
         tbl[n].y = RW'(r);
         tbl[n].border = (r < 2) || (c < 2);
         tbl[n].win = '0;
         tbl[n].care = '0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               int k, m, v;
               bit z;
               k = i * 3 + j;
               m = n - (2 - j);
               v = m - (2 - i) * LW;
               z = zero_en && ((i == 0 && r < 2) || (i == 1 && r < 1) ||
                               (j == 0 && c < 2) || (j == 1 && c < 1));
               if (z) begin
                  tbl[n].care[(8-k)*DW +: DW] = '1;
               end else if (m >= 0 && v >= 0) begin
                  tbl[n].win[(8-k)*DW +: DW] = DW'(v);
                  tbl[n].care[(8-k)*DW +: DW] = '1;
               end
            end
         end
      end

      // reset with valid data present
      iRST = 1'b1; iSOF = 1'b0; iDVAL = 1'b1; iDATA = 10'h3FF;
      for (int t = 0; t < 2; t++) begin
         step();
         chk("rst dval", WW'(oDVAL), '0, '1);
         chk("rst win", oWIN, '0, '1);
         chk("rst border", WW'(oBORDER), WW'(1), '1);
         chk("rst x", WW'(oX), '0, '1);
         chk("rst y", WW'(oY), '0, '1);
      end
      iRST = 1'b0; iDVAL = 1'b0;

      // continuous ramp
      iSOF = 1'b1;
      step();
      iSOF = 1'b0;
      chk("sof idle dval", WW'(oDVAL), '0, '1);
      for (int n = 0; n < 24; n++) begin
         pix(1'b0, DW'(n));
         chk_vec("ramp", n, 1'b1);
      end
      chk("ramp (2,2) full win", oWIN, tbl[23].win, '1);

      // same ramp with 3 idle cycles after every pixel
      iSOF = 1'b1;
      step();
      iSOF = 1'b0;
      for (int n = 0; n < 24; n++) begin
         pix(1'b0, DW'(n));
         chk_vec("gap", n, 1'b1);
         for (int g = 0; g < 3; g++) begin
            step();
            chk($sformatf("gap idle dval n=%0d", n), WW'(oDVAL), '0, '1);
            chk($sformatf("gap hold win n=%0d", n), oWIN, tbl[n].win, tbl[n].care);
         end
      end

      // row 3 continues from previous frame end; check wrap 7 -> 0
      for (int n = 0; n < 8; n++) pix(1'b0, DW'(n));
      chk("wrap x7", WW'(oX), WW'(7), '1);
      chk("wrap y3", WW'(oY), WW'(3), '1);
      pix(1'b0, 10'd1);
      chk("wrap x0", WW'(oX), '0, '1);
      chk("wrap y4", WW'(oY), WW'(4), '1);
      pix(1'b0, 10'd2);
      pix(1'b1, 10'h155);
      chk("sof+dval x", WW'(oX), '0, '1);
      chk("sof+dval y", WW'(oY), '0, '1);
      chk("sof+dval p22", oWIN, WW'(10'h155), WW'({DW{1'b1}}));
      chk("sof+dval border", WW'(oBORDER), WW'(1), '1);
      pix(1'b0, 10'h0AA);
      chk("after sof x", WW'(oX), WW'(1), '1);
      chk("after sof y", WW'(oY), '0, '1);

      // mid-frame reset at (5,2)
      iSOF = 1'b1;
      step();
      iSOF = 1'b0;
      for (int n = 0; n < 22; n++) pix(1'b0, DW'(n));
      chk("pre-rst x", WW'(oX), WW'(5), '1);
      chk("pre-rst y", WW'(oY), WW'(2), '1);
      iRST = 1'b1; iDVAL = 1'b1; iDATA = 10'h2AA;
      step();
      iRST = 1'b0; iDVAL = 1'b0;
      chk("midrst dval", WW'(oDVAL), '0, '1);
      chk("midrst win", oWIN, '0, '1);
      chk("midrst border", WW'(oBORDER), WW'(1), '1);
      chk("midrst x", WW'(oX), '0, '1);
      chk("midrst y", WW'(oY), '0, '1);
      pix(1'b0, 10'd5);
      chk("postrst dval", WW'(oDVAL), WW'(1), '1);
      chk("postrst x", WW'(oX), '0, '1);
      chk("postrst y", WW'(oY), '0, '1);
      chk("postrst border", WW'(oBORDER), WW'(1), '1);
      chk("postrst row2", oWIN, WW'(5), WW'({3*DW{1'b1}}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
